// File: rtl/audio_capture_ctrl.sv
`timescale 1ns/1ps
// Left-channel I2S capture from the codec ADC pins with windowed peak-level
// reporting over a valid/ready handshake and a sticky overrun flag.
module audio_capture_ctrl #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int WINDOW_LOG2  = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    audio_interface_ADCDAT,
    input  logic                    audio_interface_ADCLRCK,
    input  logic                    audio_interface_BCLK,
    input  logic                    enable,
    output logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic                    sample_valid,
    output logic [SAMPLE_WIDTH-1:0] level_data,
    output logic                    level_valid,
    input  logic                    level_ready,
    output logic                    overrun,
    input  logic                    overrun_clear,
    output logic                    busy
);

    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0]        CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]        LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [WINDOW_LOG2-1:0]  WIN_ZERO = WINDOW_LOG2'(0);
    localparam logic [WINDOW_LOG2-1:0]  WIN_ONE  = WINDOW_LOG2'(1);
    localparam logic [WINDOW_LOG2-1:0]  WIN_LAST = {WINDOW_LOG2{1'b1}};
    localparam logic [SAMPLE_WIDTH-1:0] SMP_ZERO = SAMPLE_WIDTH'(0);
    localparam logic [SAMPLE_WIDTH-1:0] SMP_ONE  = SAMPLE_WIDTH'(1);
    localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [SAMPLE_WIDTH-1:0] MAX_POS  = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_SKIP       = 3'd2,
        ST_SHIFT      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    // Magnitude with the most negative code clamped so it still fits the width.
    function automatic logic [SAMPLE_WIDTH-1:0] abs_sat(input logic [SAMPLE_WIDTH-1:0] x);
        logic [SAMPLE_WIDTH-1:0] r;
        if (x[SAMPLE_WIDTH-1] == 1'b0) begin
            r = x;
        end else if (x == MOST_NEG) begin
            r = MAX_POS;
        end else begin
            r = (~x) + SMP_ONE;
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0]  bclk_sync_q, lrck_sync_q, dat_sync_q;
    logic                    bclk_prev_q, rise_q, dat_smp_q, lrck_smp_q, lrck_prev_q;
    state_t                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] sample_data_q, sample_data_d, level_data_q, level_data_d;
    logic [SAMPLE_WIDTH-1:0] acc_q, acc_d, cur_abs_s, peak_s;
    logic [WINDOW_LOG2-1:0]  win_cnt_q, win_cnt_d;
    logic                    sample_valid_q, sample_valid_d, level_valid_q, level_valid_d;
    logic                    overrun_q, overrun_d, busy_q, busy_d, done_s, ovr_set_s;

    // Pin synchronizers; rise_q and the data/frame samples come out aligned.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_sync_q <= {SYNC_STAGES{1'b0}};
            lrck_sync_q <= {SYNC_STAGES{1'b0}};
            dat_sync_q  <= {SYNC_STAGES{1'b0}};
            bclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            dat_smp_q   <= 1'b0;
            lrck_smp_q  <= 1'b0;
            lrck_prev_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], audio_interface_BCLK};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], audio_interface_ADCLRCK};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], audio_interface_ADCDAT};
            bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
            rise_q      <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
            dat_smp_q   <= dat_sync_q[SYNC_STAGES-1];
            lrck_smp_q  <= lrck_sync_q[SYNC_STAGES-1];
            if (rise_q) begin
                lrck_prev_q <= lrck_smp_q;
            end
        end
    end

    // FSM state register and shift path
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= SMP_ZERO;
            bit_cnt_q <= CNT_ZERO;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic; the rise after the frame edge is the I2S delay slot.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (!enable) begin
            state_d   = ST_IDLE;
            bit_cnt_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (rise_q && lrck_prev_q && !lrck_smp_q) begin
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_WAIT_FRAME;
                    end
                end
                ST_SKIP: begin
                    if (rise_q) begin
                        shift_d   = {shift_q[SAMPLE_WIDTH-2:0], dat_smp_q};
                        bit_cnt_d = CNT_ONE;
                        state_d   = ST_SHIFT;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_SHIFT: begin
                    if (!rise_q) begin
                        state_d = ST_SHIFT;
                    end else if (lrck_smp_q && (bit_cnt_q != LAST_BIT)) begin
                        state_d   = ST_WAIT_FRAME;
                        bit_cnt_d = CNT_ZERO;
                    end else begin
                        shift_d   = {shift_q[SAMPLE_WIDTH-2:0], dat_smp_q};
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end
                end
                ST_DONE: begin
                    state_d   = ST_WAIT_FRAME;
                    bit_cnt_d = CNT_ZERO;
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Output and peak-window logic; the DONE cycle is the window-completion cycle.
    always_comb begin
        cur_abs_s      = abs_sat(sample_data_q);
        peak_s         = (cur_abs_s > acc_q) ? cur_abs_s : acc_q;
        done_s         = (state_q == ST_DONE) && enable;
        sample_data_d  = sample_data_q;
        sample_valid_d = (state_d == ST_DONE);
        acc_d          = acc_q;
        win_cnt_d      = win_cnt_q;
        level_data_d   = level_data_q;
        level_valid_d  = level_valid_q;
        ovr_set_s      = 1'b0;
        busy_d         = (state_d != ST_IDLE);
        if (state_d == ST_DONE) begin
            sample_data_d = shift_d;
        end else begin
            sample_data_d = sample_data_q;
        end
        if (!enable) begin
            acc_d     = SMP_ZERO;
            win_cnt_d = WIN_ZERO;
        end else if (done_s) begin
            win_cnt_d = win_cnt_q + WIN_ONE;
            acc_d     = (win_cnt_q == WIN_LAST) ? SMP_ZERO : peak_s;
        end else begin
            acc_d     = acc_q;
            win_cnt_d = win_cnt_q;
        end
        if (done_s && (win_cnt_q == WIN_LAST)) begin
            if (!level_valid_q || level_ready) begin
                level_data_d  = peak_s;
                level_valid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (level_valid_q && level_ready) begin
            level_valid_d = 1'b0;
        end else begin
            level_valid_d = level_valid_q;
        end
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clear) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Registered outputs and window state
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sample_data_q  <= SMP_ZERO;
            sample_valid_q <= 1'b0;
            level_data_q   <= SMP_ZERO;
            level_valid_q  <= 1'b0;
            overrun_q      <= 1'b0;
            busy_q         <= 1'b0;
            acc_q          <= SMP_ZERO;
            win_cnt_q      <= WIN_ZERO;
        end else begin
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            level_data_q   <= level_data_d;
            level_valid_q  <= level_valid_d;
            overrun_q      <= overrun_d;
            busy_q         <= busy_d;
            acc_q          <= acc_d;
            win_cnt_q      <= win_cnt_d;
        end
    end

    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign level_data   = level_data_q;
    assign level_valid  = level_valid_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_audio_capture_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for audio_capture_ctrl: I2S frames in, strobes and level
// handshakes checked against hand-computed expectations.
module tb_audio_capture_ctrl;

    localparam int  SW        = 16;
    localparam int  WL        = 2;
    localparam int  SS        = 2;
    localparam time BCLK_HALF = 80ns;

    // Four-sample windows; hand-computed peaks: 7FFF, 0100, 0200, 0300, 0400.
    localparam logic [15:0] WIN [0:19] = '{
        16'h0010, 16'hFFF0, 16'h8000, 16'h0005,
        16'h0100, 16'hFF00, 16'h0050, 16'h0000,
        16'h0200, 16'h0010, 16'hFE00, 16'h0001,
        16'h0300, 16'h0001, 16'h0002, 16'h0003,
        16'h0010, 16'hFC00, 16'h0020, 16'h0030
    };

    logic          clk = 1'b0;
    logic          rst, adcdat, adclrck, bclk, enable;
    logic          ready_man, ready_auto, clr_man, clr_auto;
    logic          level_ready_s, overrun_clear_s;
    logic [SW-1:0] sample_data, level_data;
    logic          sample_valid, level_valid, overrun, busy;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            strobe_cnt = 0;
    int            rdy_req = 0, rdy_ack = 0, clr_req = 0, clr_ack = 0;
    logic [15:0]   exp_smp[$];
    logic [15:0]   exp_lvl[$];

    assign level_ready_s   = ready_man | ready_auto;
    assign overrun_clear_s = clr_man | clr_auto;

    audio_capture_ctrl #(.SAMPLE_WIDTH(SW), .WINDOW_LOG2(WL), .SYNC_STAGES(SS)) dut (
        .clk_clk                 (clk),
        .reset_reset             (rst),
        .audio_interface_ADCDAT  (adcdat),
        .audio_interface_ADCLRCK (adclrck),
        .audio_interface_BCLK    (bclk),
        .enable                  (enable),
        .sample_data             (sample_data),
        .sample_valid            (sample_valid),
        .level_data              (level_data),
        .level_valid             (level_valid),
        .level_ready             (level_ready_s),
        .overrun                 (overrun),
        .overrun_clear           (overrun_clear_s),
        .busy                    (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and every accepted level.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sample_valid === 1'b1) begin
                strobe_cnt++;
                if (exp_smp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got 0x%0h, expected no strobe", sample_data);
                end else begin
                    check("sample_data", 32'(sample_data), 32'(exp_smp.pop_front()));
                end
            end
            if (level_valid === 1'b1 && level_ready_s === 1'b1) begin
                if (exp_lvl.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_level: got 0x%0h, expected no level", level_data);
                end else begin
                    check("level_data", 32'(level_data), 32'(exp_lvl.pop_front()));
                end
            end
        end
    end

    // Drives ready/clear for exactly the DONE cycle of the next strobe when armed.
    initial begin
        ready_auto = 1'b0;
        clr_auto   = 1'b0;
        forever begin
            @(negedge clk);
            ready_auto = 1'b0;
            clr_auto   = 1'b0;
            if (sample_valid === 1'b1 && rdy_req != rdy_ack) begin
                ready_auto = 1'b1;
                rdy_ack++;
            end
            if (sample_valid === 1'b1 && clr_req != clr_ack) begin
                clr_auto = 1'b1;
                clr_ack++;
            end
        end
    end

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b0; adclrck = 1'b1; adcdat = 1'b0;
            #BCLK_HALF; bclk = 1'b1; #BCLK_HALF;
        end
    endtask

    // One 64-slot I2S frame; optional LRCK rise or enable drop part-way through the left word.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int lr_abort, input int en_abort, input bit expect_strobe);
        if (expect_strobe) exp_smp.push_back(l);
        for (int i = 0; i < 64; i++) begin
            bclk    = 1'b0;
            adclrck = (i >= 32) || (lr_abort > 0 && i > lr_abort);
            adcdat  = (i >= 1 && i <= 16) ? l[16-i] : ((i >= 33 && i <= 48) ? r[48-i] : 1'b0);
            if (en_abort > 0 && i == en_abort + 1) begin
                @(posedge clk); #1 enable = 1'b0;
                @(posedge clk); #1 check("abort_busy", 32'(busy), 32'h0);
            end
            #BCLK_HALF; bclk = 1'b1; #BCLK_HALF;
        end
        if (en_abort > 0) begin
            @(posedge clk); #1 enable = 1'b1;
        end
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 ready_man = 1'b1;
        @(posedge clk); #1 ready_man = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; ready_man = 1'b0; clr_man = 1'b0;
        bclk = 1'b0; adclrck = 1'b1; adcdat = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            bclk = ~bclk; adclrck = ~adclrck; adcdat = ~adcdat;
        end
        check("rst_sample_data", 32'(sample_data), 32'h0);
        check("rst_sample_valid", 32'(sample_valid), 32'h0);
        check("rst_level_data", 32'(level_data), 32'h0);
        check("rst_level_valid", 32'(level_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; bclk = 1'b0; adclrck = 1'b1; adcdat = 1'b0;

        // Disabled: a full frame must not strobe.
        send_frame(16'h5555, 16'h0000, 0, 0, 1'b0);
        check("disabled_strobes", 32'(strobe_cnt), 32'd0);
        check("disabled_busy", 32'(busy), 32'h0);

        enable = 1'b1;
        preamble(4);
        send_frame(16'h1234, 16'hFFFF, 0, 0, 1'b1);
        check("single_strobe_cnt", 32'(strobe_cnt), 32'd1);
        check("enabled_busy", 32'(busy), 32'h1);

        // Restart the window from zero.
        @(posedge clk); #1 enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        preamble(4);

        for (int w = 0; w < 5; w++) begin
            if (w == 0) exp_lvl.push_back(16'h7FFF);
            if (w == 3) exp_lvl.push_back(16'h0300);
            if (w == 4) exp_lvl.push_back(16'h0400);
            for (int k = 0; k < 4; k++) begin
                if (w == 2 && k == 3) clr_req++;
                if (w == 4 && k == 3) rdy_req++;
                send_frame(WIN[w*4+k], 16'hAAAA, 0, 0, 1'b1);
            end
            if (w == 0) begin
                check("win1_level_valid", 32'(level_valid), 32'h1);
                check("win1_level_data", 32'(level_data), 32'h7FFF);
            end
            if (w == 1) begin
                check("win2_overrun", 32'(overrun), 32'h1);
                check("win2_level_held", 32'(level_data), 32'h7FFF);
                check("win2_level_valid", 32'(level_valid), 32'h1);
            end
            if (w == 2) begin
                check("win3_set_beats_clear", 32'(overrun), 32'h1);
                check("win3_level_held", 32'(level_data), 32'h7FFF);
                @(posedge clk); #1 clr_man = 1'b1;
                @(posedge clk); #1 clr_man = 1'b0;
                check("overrun_cleared", 32'(overrun), 32'h0);
                pulse_ready();
                check("accept_clears_valid", 32'(level_valid), 32'h0);
            end
            if (w == 3) begin
                check("win4_level_valid", 32'(level_valid), 32'h1);
                check("win4_level_data", 32'(level_data), 32'h0300);
            end
            if (w == 4) begin
                check("win5_simul_valid", 32'(level_valid), 32'h1);
                check("win5_simul_data", 32'(level_data), 32'h0400);
                check("win5_simul_overrun", 32'(overrun), 32'h0);
                pulse_ready();
            end
        end

        // Aborts: enable drop after 7 bits, LRCK rise after 10 bits, then a clean frame.
        send_frame(16'h7E7E, 16'h0000, 0, 7, 1'b0);
        send_frame(16'h6666, 16'h0000, 10, 0, 1'b0);
        check("abort_no_strobe", 32'(strobe_cnt), 32'd21);
        send_frame(16'h0ABC, 16'h0000, 0, 0, 1'b1);
        check("recover_strobe_cnt", 32'(strobe_cnt), 32'd22);

        repeat (10) @(posedge clk);
        check("samples_left", 32'(exp_smp.size()), 32'd0);
        check("levels_left", 32'(exp_lvl.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
